rom8_burst_arbiter: RTL
=======================

# rom8_burst_arbiter

Two-requester, round-robin read controller that shares the single registered read port of an 8-entry, N-bit ROM (`rom8`) between two clients. Each client requests a burst of 1–8 sequential reads with 3-bit address wrap-around. The controller drives the ROM address, then returns the data beats tagged with the owning requester. It sits between the clients and one `rom8` instance. It does not drive the ROM's `clr`.

## Interface
- `N`, default 4: data width, equal to the attached `rom8` width.
- `clk`  in  1  single system clock, rising edge.
- `clr`  in  1  asynchronous, active-high reset.
- `req0`, `req1`  in  1  burst request, held by the client until its grant.
- `add0`, `add1`  in  3  burst start address, stable while the matching `req` is high.
- `len0`, `len1`  in  3  burst length minus 1 (0 → 1 beat, 7 → 8 beats).
- `gnt0`, `gnt1`  out  1  one-cycle grant pulse; request accepted.
- `busy`  out  1  high while a burst is issuing addresses.
- `rom_add`  out  3  address to `rom8.add`, registered.
- `rom_q`  in  N  from `rom8.q`; the ROM has a 1-cycle registered read.
- `rd_valid`  out  1  read data beat valid.
- `rd_id`  out  1  owner of the current beat (0 or 1).
- `rd_data`  out  N  beat data, a direct pass-through of `rom_q`.

## Operation
- **Reset.** `clr` high immediately forces the following, regardless of `clk`:
  - state = IDLE
  - `rom_add` = 0, `gnt0` = `gnt1` = 0, `busy` = 0, `rd_valid` = 0, `rd_id` = 0
  - beat counter = 0
  - round-robin pointer `last` = 1, so requester 0 wins the first tie.
- **States.**
  - IDLE: no address issue in progress.
  - BURST: one address issued per cycle; `busy` = 1.
- **Arbitration.** Performed at a clock edge when state = IDLE, or when state = BURST with counter = 0.
  - Only one `req` high: grant it.
  - Both `req` high: grant requester `!last`.
  - No `req`: go to or stay in IDLE.
- **On a grant to requester i:**
  - `gnt_i` <= 1 for exactly one cycle.
  - `rom_add` <= `add_i`, counter <= `len_i`, owner <= i, `last` <= i, state <= BURST.
- **In BURST with counter ≠ 0:** `rom_add` <= `rom_add` + 1, modulo 8 (7 → 0 wraps); counter decrements.
- **In BURST with counter = 0:** re-arbitrate. A pending request starts the next burst on the same edge (zero bubble); otherwise state <= IDLE.
- **Data return.**
  - `rd_valid` <= (state == BURST) and `rd_id` <= owner, both registered.
  - `rd_data` = `rom_q`.
  - Each beat corresponds to the `rom_add` value that was present in the previous cycle.
- **Request sampling.** `req` is ignored while BURST has counter ≠ 0.
  - A client must drop `req` in its `gnt` cycle, or it is taken as a new request at the next arbitration point.
  - `add`/`len` are sampled only at the grant edge.
- **Mid-operation reset.** `clr` during BURST aborts the burst. No further `rd_valid` beats are produced, including the in-flight one.

## Timing
- Request sampled at edge T, where the controller is IDLE.
- Edge T: `gnt` high and `rom_add` = a during cycle T..T+1.
- Edge T+k: `rom_add` = a+k, for k = 0..len.
- Beat k is valid in the cycle after edge T+k+1.
  - First-data latency: 2 cycles from the request edge.
  - Beats are contiguous: len+1 consecutive `rd_valid` cycles.
- Back-to-back bursts produce one continuous `rd_valid` stream. `rd_id` switches on the first beat of the new owner.
- Maximum throughput: 1 beat/cycle. A grant to the other requester occurs at most every (len+1) cycles per burst.

## Test plan
ROM initialised to `rom[k]` = 8−k, with N = 4.
- **Single read.** `req0` with `add0`=5, `len0`=0 after reset → `gnt0` for 1 cycle; one beat with `rd_data`=3, `rd_id`=0, valid 2 cycles after the request edge; then `busy`=0.
- **Wrapping burst.** `req1` with `add1`=6, `len1`=3 → `rom_add` sequence 6,7,0,1; 4 consecutive beats 2,1,8,7 with `rd_id`=1.
- **Simultaneous first requests.** Both requests at once, each with len=1, `add0`=0, `add1`=4 → `gnt0` first, then `gnt1` with zero bubble; beats 8,7 (id 0) then 4,3 (id 1) on 4 consecutive cycles.
- **Fairness.** Both `req` held continuously, re-raised after each grant, len=0 → grants alternate 0,1,0,1; `rd_valid` stays high continuously.
- **Reset mid-burst.** Assert `clr` mid-burst (`add`=0, len=7) → all outputs 0 immediately and no further `rd_valid`. After release, `req0` with `add0`=2, len=0 → beat 6.
- **Idle.** No requests for 20 cycles → `gnt`, `busy`, and `rd_valid` all stay 0, and `rom_add` holds its value.

Source files
------------

// File: rtl/rom8_burst_arbiter.sv
// Round-robin read controller sharing one registered 8-entry ROM port between two burst clients.
// Latency: grant on the request edge, first beat valid two cycles after the request edge, then 1 beat/cycle.
// Backpressure: clients hold req until their one-cycle gnt; req is ignored mid-burst, no output stall.
//
// Ports:
//   clk, clr            clock, asynchronous active-high reset
//   req*/add*/len*      per-client burst request, start address, length-1
//   gnt*                one-cycle grant pulse
//   busy                high while addresses are being issued
//   rom_add / rom_q     ROM address out, ROM registered data in
//   rd_valid/rd_id/rd_data  returned beats tagged with owner
module rom8_burst_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         req0,
  input  logic         req1,
  input  logic [2:0]   add0,
  input  logic [2:0]   add1,
  input  logic [2:0]   len0,
  input  logic [2:0]   len1,
  output logic         gnt0,
  output logic         gnt1,
  output logic         busy,
  output logic [2:0]   rom_add,
  input  logic [N-1:0] rom_q,
  output logic         rd_valid,
  output logic         rd_id,
  output logic [N-1:0] rd_data
);

  typedef enum logic {IDLE, BURST} state_t;

  state_t     state;
  logic [2:0] cnt;
  logic       owner;
  logic       last;

  logic arb_point;
  logic any_req;
  logic pick1;

  // Arbitration happens when idle or on the final address of a burst,
  // which lets a pending request follow with no bubble.
  assign arb_point = (state == IDLE) || (cnt == 3'd0);
  assign any_req   = req0 || req1;
  // Requester 1 wins when alone, or on a tie when requester 0 went last.
  assign pick1     = req1 && (!req0 || !last);

  // The ROM output register already aligns data with the registered valid/id.
  assign rd_data = rom_q;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state    <= IDLE;
      rom_add  <= 3'd0;
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      busy     <= 1'b0;
      rd_valid <= 1'b0;
      rd_id    <= 1'b0;
      cnt      <= 3'd0;
      owner    <= 1'b0;
      last     <= 1'b1;
    end else begin
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      // Beat for the address issued last cycle comes out of the ROM now.
      rd_valid <= (state == BURST);
      rd_id    <= owner;
      if (arb_point) begin
        if (any_req) begin
          if (pick1) begin
            gnt1    <= 1'b1;
            rom_add <= add1;
            cnt     <= len1;
            owner   <= 1'b1;
            last    <= 1'b1;
          end else begin
            gnt0    <= 1'b1;
            rom_add <= add0;
            cnt     <= len0;
            owner   <= 1'b0;
            last    <= 1'b0;
          end
          state <= BURST;
          busy  <= 1'b1;
        end else begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      end else begin
        // Mid-burst: 3-bit address wraps 7 -> 0 naturally.
        rom_add <= rom_add + 3'd1;
        cnt     <= cnt - 3'd1;
      end
    end
  end

endmodule
